// File: rtl/bram_arb_pkg.sv
// Shared definitions for the Bram read arbiter: tag sizing, pipeline stage
// record and the fixed read latency from handshake to response.
package bram_arb_pkg;

    // Handshake to rsp_valid, in clock cycles.
    localparam int BRAM_ARB_LATENCY = 2;

    // Largest supported requester count and the tag width it needs.
    localparam int BRAM_ARB_MAX_REQ   = 8;
    localparam int BRAM_ARB_TAG_MAX_W = 3;

    // Tag width for a given requester count: clog2, but never below one bit.
    function automatic int arb_tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef logic [BRAM_ARB_TAG_MAX_W-1:0] arb_tag_t;

    // One slot of the read pipeline: which requester owns the read in flight.
    typedef struct packed {
        logic     valid;
        arb_tag_t tag;
    } arb_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches upward from the pointer,
// modulo NUM_REQ, and grants the first active request. Also returns the
// pointer value to load after the grant (winner + 1, wrapping).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [PTR_W-1:0]   pointer,
    input  logic [NUM_REQ-1:0] request,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_index,
    output logic               grant_valid,
    output logic [PTR_W-1:0]   pointer_next
);

    // (base + offset) mod NUM_REQ, with base already below NUM_REQ.
    function automatic int wrap_index(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum;
    endfunction

    // Priority search starting at the pointer; the first hit wins.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output
        // a default first, so no path can leave a stale value (no latch).
        grant_valid = 1'b0;
        grant_index = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && request[wrap_index(int'(pointer), k)]) begin
                grant_valid = 1'b1;
                grant_index = PTR_W'(wrap_index(int'(pointer), k));
            end
        end
    end

    // Expand the winning index to a one-hot grant vector.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_valid && (grant_index == PTR_W'(i));
        end
    end

    // Next pointer: one past the winner, or unchanged when nobody won.
    always_comb begin
        pointer_next = pointer;
        if (grant_valid) begin
            pointer_next = (grant_index == PTR_W'(NUM_REQ - 1)) ? '0 : grant_index + 1'b1;
        end
    end

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares one single-port, 1-cycle registered-read Bram between NUM_REQ
// requesters. Round-robin grant on a valid/ready handshake, one read issued
// per cycle, and each returned word steered back to its owner through a
// one-hot rsp_valid two cycles after the handshake.
//
// Optional feature, macro BRAM_ARB_LOCK_EN: a requester that handshakes with
// req_lock set holds the grant until it handshakes with req_lock clear or
// drops req_valid. Without the macro req_lock is ignored and no lock state
// exists.
module bram_read_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_SIZE = 8,
    parameter int RAM_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [RAM_WIDTH-1:0]         rsp_data,
    output logic                         ram_enable,
    output logic [ADDR_SIZE-1:0]         ram_address,
    input  logic [RAM_WIDTH-1:0]         ram_data
);

    localparam int TAG_W = arb_tag_width(NUM_REQ);

    logic [TAG_W-1:0]     pointer_q;
    logic [TAG_W-1:0]     pointer_next;
    logic [TAG_W-1:0]     grant_index;
    logic [NUM_REQ-1:0]   arb_request;
    logic [NUM_REQ-1:0]   grant;
    logic                 grant_valid;
    logic [ADDR_SIZE-1:0] grant_addr;
    logic [ADDR_SIZE-1:0] ram_address_q;
    arb_stage_t           stage1_q;
    arb_stage_t           stage2_q;

`ifdef BRAM_ARB_LOCK_EN
    logic             lock_active_q;
    logic [TAG_W-1:0] lock_owner_q;
    logic             lock_holds;

    // The lock only restricts arbitration while its owner is still asking.
    assign lock_holds = lock_active_q && req_valid[lock_owner_q];

    // Mask every requester except the owner while the lock holds.
    always_comb begin
        arb_request = req_valid;
        if (lock_holds) begin
            arb_request               = '0;
            arb_request[lock_owner_q] = 1'b1;
        end
    end

    // Lock ownership: taken or dropped on each handshake, released when the
    // owner stops requesting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
        end else if (grant_valid) begin
            lock_active_q <= req_lock[grant_index];
            lock_owner_q  <= grant_index;
        end else if (lock_active_q && !req_valid[lock_owner_q]) begin
            lock_active_q <= 1'b0;
        end
    end
`else
    logic unused_lock;

    // Without the lock feature req_lock has no effect.
    assign unused_lock = ^req_lock;
    assign arb_request = req_valid;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (TAG_W)
    ) u_rr_arbiter (
        .pointer      (pointer_q),
        .request      (arb_request),
        .grant        (grant),
        .grant_index  (grant_index),
        .grant_valid  (grant_valid),
        .pointer_next (pointer_next)
    );

    // A grant is only ever given to a valid requester, so ready == handshake.
    assign req_ready = grant;

    // Select the address of the requester being accepted this cycle.
    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_index == TAG_W'(i)) begin
                grant_addr = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
            end
        end
    end

    // Round-robin pointer: advances past the winner on every handshake.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: clocked state uses non-blocking '<=' so every register samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            pointer_q <= '0;
        end else begin
            pointer_q <= pointer_next;
        end
    end

    // Read issue and two-stage owner-tag pipeline.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the tag stages are cleared on reset (unlike a data path) because
        // a stale valid bit would deliver a response nobody asked for.
        if (reset) begin
            stage1_q      <= '0;
            stage2_q      <= '0;
            ram_address_q <= '0;
        end else begin
            stage1_q.valid <= grant_valid;
            stage1_q.tag   <= BRAM_ARB_TAG_MAX_W'(grant_index);
            stage2_q       <= stage1_q;
            if (grant_valid) begin
                ram_address_q <= grant_addr;
            end
        end
    end

    assign ram_enable  = stage1_q.valid;
    assign ram_address = ram_address_q;

    // Bram output is valid the cycle after the enable; steer it to the owner.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = stage2_q.valid && (stage2_q.tag == BRAM_ARB_TAG_MAX_W'(i));
        end
    end

    assign rsp_data = ram_data;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Self-checking bench for bram_read_arbiter with two requesters and a Bram
// model preloaded with mem[a] = a ^ 8'hA5. The reference model tracks the
// round-robin pointer, the lock owner and a queue of accepted reads stamped
// with their acceptance cycle; expectations follow from those.
module tb_bram_read_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_lock;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              ram_enable;
    logic [AW-1:0]     ram_address;
    logic [DW-1:0]     ram_data;
    logic [DW-1:0]     mem [0:255];

    always #5 clock = ~clock;

    bram_read_arbiter #(
        .NUM_REQ   (N),
        .ADDR_SIZE (AW),
        .RAM_WIDTH (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .ram_enable  (ram_enable),
        .ram_address (ram_address),
        .ram_data    (ram_data)
    );

    // Bram: one-cycle registered read, gated by ram_enable.
    always @(posedge clock) begin
        if (ram_enable) ram_data <= mem[ram_address];
    end

    typedef struct {
        int          owner;
        logic [AW-1:0] addr;
        int          acc;
    } read_t;

    read_t         pend[$];
    int            cyc;
    int            m_ptr;
    logic [AW-1:0] m_last_addr;
    bit            m_lock_act;
    int            m_lock_own;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Winner for a request vector under the model state, or -1 for none.
    function automatic int exp_grant(input logic [N-1:0] v);
`ifdef BRAM_ARB_LOCK_EN
        if (m_lock_act && v[m_lock_own]) return m_lock_own;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input logic [N-1:0] v, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [N-1:0] lk);
        int            g;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rsp;
        logic          exp_en;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        read_t         r;
        req_valid = v;
        req_addr  = {a1, a0};
        req_lock  = lk;
        @(negedge clock);
        g         = exp_grant(v);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_en   = 1'b0;
        exp_addr = m_last_addr;
        exp_rsp  = '0;
        exp_data = '0;
        foreach (pend[j]) begin
            if (pend[j].acc == cyc - 1) begin
                exp_en   = 1'b1;
                exp_addr = pend[j].addr;
            end
            if (pend[j].acc == cyc - 2) begin
                exp_rsp[pend[j].owner] = 1'b1;
                exp_data = pend[j].addr ^ 8'hA5;
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("ram_enable", 32'(ram_enable), 32'(exp_en));
        check("ram_address", 32'(ram_address), 32'(exp_addr));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp != '0) check("rsp_data", 32'(rsp_data), 32'(exp_data));
        m_last_addr = exp_addr;
        while (pend.size() > 0 && pend[0].acc <= cyc - 2) void'(pend.pop_front());
`ifdef BRAM_ARB_LOCK_EN
        if (m_lock_act && !v[m_lock_own]) m_lock_act = 1'b0;
`endif
        if (g >= 0) begin
            r.owner = g;
            r.addr  = (g == 1) ? a1 : a0;
            r.acc   = cyc;
            pend.push_back(r);
            m_ptr = (g + 1) % N;
`ifdef BRAM_ARB_LOCK_EN
            m_lock_act = lk[g];
            m_lock_own = g;
`endif
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 8'h00, 8'h00, '0);
    endtask

    // Asynchronous reset in the middle of a cycle with reads in flight.
    task automatic reset_mid_cycle();
        req_valid = '0;
        req_lock  = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ram_enable", 32'(ram_enable), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        pend.delete();
        m_ptr       = 0;
        m_last_addr = '0;
        m_lock_act  = 1'b0;
        m_lock_own  = 0;
        cyc += 2;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        m_ptr       = 0;
        m_last_addr = '0;
        m_lock_act  = 1'b0;
        m_lock_own  = 0;
        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_lock    = '0;

        // Reset state.
        #3;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_ram_enable", 32'(ram_enable), 32'd0);
        check("reset_ram_address", 32'(ram_address), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single request: 0x10 -> 0xB5 two cycles later.
        step(2'b01, 8'h10, 8'h00, 2'b00);
        idle(3);

        // Contention: alternating grants and responses.
        for (int i = 0; i < 8; i++) step(2'b11, 8'h01, 8'h02, 2'b00);
        idle(2);

        // Pointer fairness: req1 alone, then both.
        for (int i = 0; i < 3; i++) step(2'b10, 8'h00, 8'h20 + 8'(i), 2'b00);
        for (int i = 0; i < 2; i++) step(2'b11, 8'h30, 8'h31, 2'b00);
        idle(2);

        // Idle: address must hold, no enables or responses.
        idle(10);

        // Lock sequence (alternates when the lock feature is absent).
        step(2'b01, 8'h40, 8'h50, 2'b01);
        for (int i = 0; i < 4; i++) step(2'b11, 8'h41 + 8'(i), 8'h51, 2'b01);
        step(2'b11, 8'h45, 8'h52, 2'b00);
        step(2'b11, 8'h46, 8'h53, 2'b00);
        step(2'b11, 8'h47, 8'h54, 2'b00);
        idle(2);

        // Reset mid-flight: two reads dropped, pointer back to 0.
        step(2'b01, 8'h33, 8'h00, 2'b00);
        step(2'b01, 8'h44, 8'h00, 2'b00);
        reset_mid_cycle();
        idle(3);
        step(2'b11, 8'h60, 8'h61, 2'b00);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] v;
            logic [N-1:0] lk;
            v  = N'($urandom_range(0, 3));
            lk = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            step(v, 8'($urandom), 8'($urandom), lk);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
